// File: rtl/data_ram_resp.sv
// Word-addressed data-RAM responder with programmable wait states and a one-cycle ready/err pulse.
// Optional access statistics (rd_cnt_o/wr_cnt_o) are built when DATA_RAM_STAT_EN is defined.
module data_ram_resp #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  err_o,
  output logic                  busy_o
`ifdef DATA_RAM_STAT_EN
  ,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o
`endif
);

  localparam int unsigned IW = ADDR_WIDTH - 2;
  localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic                  r_we;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ready, r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_from_idle, w_enter_resp;
  logic                  w_acc_we, w_acc_ok, w_lat_ok, w_mem_we;
  logic [IW-1:0]         w_acc_idx;
  logic                  w_unused_lsb;

  assign w_unused_lsb = ^addr_i[1:0];

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: if (ce_i) begin
        w_cnt_next = 4'(WAIT_CYCLES);
        w_next     = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Read data is fetched on the edge entering RESP; with zero wait states that
  // is the accept edge itself, so the request is taken straight from the inputs.
  assign w_from_idle  = (r_state == S_IDLE);
  assign w_enter_resp = (w_next == S_RESP);
  assign w_acc_we     = w_from_idle ? we_i : r_we;
  assign w_acc_idx    = w_from_idle ? addr_i[ADDR_WIDTH-1:2] : r_idx;
  assign w_acc_ok     = (w_acc_idx < IW'(DEPTH));
  assign w_lat_ok     = (r_idx < IW'(DEPTH));
  assign w_mem_we     = (r_state == S_RESP) && r_we && w_lat_ok;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_from_idle && ce_i) begin
        r_we    <= we_i;
        r_idx   <= addr_i[ADDR_WIDTH-1:2];
        r_wdata <= wdata_i;
      end
      r_ready <= w_enter_resp;
      r_err   <= w_enter_resp && !w_acc_ok;
      if (w_enter_resp && !w_acc_we)
        r_rdata <= w_acc_ok ? r_mem[w_acc_idx[MW-1:0]] : '0;
    end
  end

  // Array write lands on the edge that ends RESP, before any following accept.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[r_idx[MW-1:0]] <= r_wdata;
  end

  assign rdata_o = r_rdata;
  assign ready_o = r_ready;
  assign err_o   = r_err;
  assign busy_o  = (r_state != S_IDLE);

`ifdef DATA_RAM_STAT_EN
  logic [31:0] r_rd_cnt, r_wr_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (r_state == S_RESP && !r_err) begin
      if (r_we) r_wr_cnt <= r_wr_cnt + 32'd1;
      else      r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  end

  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;
`endif

endmodule
